// File: rtl/ddr_line_write_sequencer_if.sv
// rtl/ddr_line_write_sequencer_if.sv - word stream in and DDR line write command out
interface ddr_line_write_sequencer_if #(
   parameter int ADDR_W = 28
);
   // Incoming 32-bit words from the UART word assembler
   logic [31:0]       s_word;
   logic              s_valid;
   logic              s_ready;

   // One write command per packed 256-bit line toward the DDR controller
   logic              ddr_cmd_valid;
   logic              ddr_cmd_ready;
   logic [ADDR_W-1:0] ddr_addr;
   logic [255:0]      ddr_wdata;

   // Environment side: produces words, consumes commands
   modport master (
      output s_word, s_valid, ddr_cmd_ready,
      input  s_ready, ddr_cmd_valid, ddr_addr, ddr_wdata
   );

   // Sequencer side: consumes words, produces commands
   modport slave (
      input  s_word, s_valid, ddr_cmd_ready,
      output s_ready, ddr_cmd_valid, ddr_addr, ddr_wdata
   );
endinterface

// File: rtl/ddr_line_write_sequencer.sv
// rtl/ddr_line_write_sequencer.sv - packs eight words per DDR line and issues line writes
module ddr_line_write_sequencer #(
   parameter int ADDR_W    = 28,
   parameter int ADDR_STEP = 32,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [CNT_W-1:0]      num_lines,
   ddr_line_write_sequencer_if.slave bus,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [CNT_W-1:0]      lines_written
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
   localparam logic [CNT_W-1:0]  ONE  = CNT_W'(1);

   state_t             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [CNT_W-1:0]   target_q;
   logic [CNT_W-1:0]   lines_q;
   logic [2:0]         word_idx_q;
   // Element 7 is the first word of a line and lands in bits [255:224]
   logic [7:0][31:0]   line_q;
   logic               aborted_q;
   logic               busy_q;
   logic               done_q;
   logic               fill_q;
   logic               issue_q;

   // Sequencer FSM; the status flags are updated together with every state change
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         target_q   <= '0;
         lines_q    <= '0;
         word_idx_q <= '0;
         line_q     <= '0;
         aborted_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         fill_q     <= 1'b0;
         issue_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q     <= base_addr;
                  target_q   <= num_lines;
                  lines_q    <= '0;
                  word_idx_q <= '0;
                  aborted_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  if (num_lines != '0) begin
                     state_q <= FILL;
                     fill_q  <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (abort) begin
                  // The partial line is simply abandoned; the next start refills from slot 0
                  word_idx_q <= '0;
                  aborted_q  <= 1'b1;
                  fill_q     <= 1'b0;
                  state_q    <= DONE;
                  done_q     <= 1'b1;
               end else if (bus.s_valid) begin
                  line_q[3'd7 - word_idx_q] <= bus.s_word;
                  word_idx_q                <= word_idx_q + 3'd1;
                  if (word_idx_q == 3'd7) begin
                     fill_q  <= 1'b0;
                     issue_q <= 1'b1;
                     state_q <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               // The command is never withdrawn; abort only takes effect once it is accepted
               if (bus.ddr_cmd_ready) begin
                  issue_q <= 1'b0;
                  lines_q <= lines_q + ONE;
                  addr_q  <= addr_q + STEP;
                  if (abort || (lines_q + ONE == target_q)) begin
                     aborted_q <= abort;
                     state_q   <= DONE;
                     done_q    <= 1'b1;
                  end else begin
                     state_q <= FILL;
                     fill_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               fill_q  <= 1'b0;
               issue_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // abort gates s_ready directly so the word offered in the abort cycle is refused
   assign bus.s_ready       = fill_q & ~abort;
   assign bus.ddr_cmd_valid = issue_q;
   assign bus.ddr_addr      = addr_q;
   assign bus.ddr_wdata     = line_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign aborted           = aborted_q;
   assign lines_written     = lines_q;

endmodule

// File: tb/tb_ddr_line_write_sequencer.sv
// tb/tb_ddr_line_write_sequencer.sv - randomized scoreboard bench for ddr_line_write_sequencer
module tb_ddr_line_write_sequencer;

   localparam int ADDR_W = 28;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  num_lines;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [CNT_W-1:0]  lines_written;

   ddr_line_write_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   ddr_line_write_sequencer #(.ADDR_W(ADDR_W), .ADDR_STEP(32), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .base_addr     (base_addr),
      .num_lines     (num_lines),
      .bus           (bus),
      .busy          (busy),
      .done          (done),
      .aborted       (aborted),
      .lines_written (lines_written)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] words[$];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: line i goes to base + 32*i (wrapping in 28 bits), words in arrival order top-down
   function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] base, input int i);
      exp_addr = base + ADDR_W'(i * 32);
   endfunction

   function automatic logic [255:0] pack_line(input int l);
      logic [255:0] r;
      r = '0;
      for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = words[8*l + j];
      return r;
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_s_ready"}, bus.s_ready, 0);
      check({tag, "_cmd_valid"}, bus.ddr_cmd_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_aborted"}, aborted, 0);
      check({tag, "_lines"}, lines_written, 0);
      check({tag, "_addr"}, bus.ddr_addr, 0);
      check({tag, "_wdata"}, bus.ddr_wdata, 0);
   endtask

   // abort_mode 1: abort once abort_at words accepted (mid-FILL); 2: abort while line abort_at is stalled
   // rst_mode 1: reset after 4 words; 2: reset while a command is stalled
   task automatic run_transfer(input logic [ADDR_W-1:0] base, input int n, input int valid_pct,
                               input int ready_pct, input bit seq_words, input int abort_mode,
                               input int abort_at, input int rst_mode, input bit noise);
      int cycle, widx, ncmd, last_ev, fin, stall, exp_lines;
      bit held, rdy;
      logic [ADDR_W-1:0] snap_addr;
      logic [255:0] snap_data;

      words.delete();
      for (int i = 0; i < 8 * n; i++) words.push_back(seq_words ? 32'(i) : $urandom);
      exp_lines = (abort_mode == 1) ? abort_at / 8 : (abort_mode == 2) ? abort_at + 1 : n;

      @(negedge clk);
      start = 1'b1; base_addr = base; num_lines = CNT_W'(n); abort = 1'b0;
      bus.s_valid = 1'b0; bus.ddr_cmd_ready = 1'b0;
      @(posedge clk);
      cycle = 0; widx = 0; ncmd = 0; last_ev = 0; fin = 0; stall = 0; held = 1'b0;
      snap_addr = '0; snap_data = '0;

      while (fin == 0 && cycle < 3000) begin
         @(negedge clk);
         start = 1'b0;
         cycle++;
         if (cycle == 1) begin
            check("busy_after_start", busy, 1);
            check("s_ready_after_start", bus.s_ready, (n != 0));
         end
         if (done) begin
            fin = 1;
         end else if ((rst_mode == 1 && widx == 4) || (rst_mode == 2 && bus.ddr_cmd_valid && stall >= 2)) begin
            rst = 1'b0; bus.s_valid = 1'b0; bus.ddr_cmd_ready = 1'b0; abort = 1'b0;
            @(negedge clk);
            check_reset_state(rst_mode == 1 ? "rst_fill" : "rst_issue");
            rst = 1'b1;
            fin = 2;
         end else begin
            rdy = ($urandom_range(99) < ready_pct);
            if (abort_mode == 2 && ncmd == abort_at && bus.ddr_cmd_valid) begin
               abort = 1'b1;
               rdy = (stall >= 3);
            end
            if (rst_mode == 2) rdy = 1'b0;
            if (abort_mode == 1 && widx == abort_at && !bus.ddr_cmd_valid && !abort) begin
               abort = 1'b1;
               last_ev = cycle;
            end
            if (noise && cycle == 5 && busy) begin
               start = 1'b1; base_addr = ADDR_W'($urandom); num_lines = CNT_W'($urandom);
            end
            bus.s_valid = (widx < words.size()) && ($urandom_range(99) < valid_pct);
            bus.s_word = bus.s_valid ? words[widx] : $urandom;
            bus.ddr_cmd_ready = rdy;
            #1;
            if (abort) check("s_ready_abort", bus.s_ready, 0);
            if (bus.ddr_cmd_valid) begin
               check("s_ready_in_issue", bus.s_ready, 0);
               if (held) begin
                  check("stall_addr", bus.ddr_addr, snap_addr);
                  check("stall_data", bus.ddr_wdata, snap_data);
               end
               snap_addr = bus.ddr_addr; snap_data = bus.ddr_wdata; held = 1'b1;
               if (rdy) begin
                  check("cmd_addr", bus.ddr_addr, exp_addr(base, ncmd));
                  check("cmd_data", bus.ddr_wdata, pack_line(ncmd));
                  if (ncmd == 0 && valid_pct == 100 && ready_pct == 100) check("first_cmd_cycle", cycle, 9);
                  ncmd++; last_ev = cycle; held = 1'b0; stall = 0;
               end else begin
                  stall++;
               end
            end
            if (bus.s_valid && bus.s_ready) widx++;
         end
      end

      if (fin == 0) begin
         check("timeout", 0, 1);
      end else if (fin == 1) begin
         check("done_cycle", cycle, last_ev + 1);
         check("aborted_flag", aborted, (abort_mode != 0));
         check("lines_written", lines_written, exp_lines);
         check("cmd_count", ncmd, exp_lines);
         check("final_addr", bus.ddr_addr, exp_addr(base, exp_lines));
         abort = 1'b0; bus.s_valid = 1'b0; bus.ddr_cmd_ready = 1'b0;
         @(negedge clk);
         check("done_one_cycle", done, 0);
         check("idle_busy", busy, 0);
         check("hold_lines", lines_written, exp_lines);
      end
      bus.s_valid = 1'b0; bus.ddr_cmd_ready = 1'b0; abort = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; num_lines = '0;
      bus.s_word = '0; bus.s_valid = 1'b0; bus.ddr_cmd_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b1;

      run_transfer(28'h100, 2, 100, 100, 1'b1, 0, 0, 0, 1'b0);
      run_transfer(28'h100, 2, 60, 40, 1'b1, 0, 0, 0, 1'b0);
      run_transfer(28'hFFFFFE0, 2, 100, 100, 1'b0, 0, 0, 0, 1'b0);
      run_transfer(28'h100, 3, 100, 100, 1'b0, 1, 11, 0, 1'b0);
      run_transfer(28'h200, 3, 80, 50, 1'b0, 2, 1, 0, 1'b0);
      run_transfer(28'h40, 0, 100, 100, 1'b0, 0, 0, 0, 1'b0);
      run_transfer(28'h80, 2, 70, 70, 1'b0, 0, 0, 0, 1'b1);
      run_transfer(28'h300, 1, 100, 100, 1'b0, 0, 0, 1, 1'b0);
      run_transfer(28'h400, 1, 90, 60, 1'b0, 0, 0, 0, 1'b0);
      run_transfer(28'h500, 1, 100, 0, 1'b0, 0, 0, 2, 1'b0);
      run_transfer(28'h600, 2, 100, 100, 1'b1, 0, 0, 0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         int n, mode, at;
         n = $urandom_range(4, 1);
         mode = $urandom_range(3);
         if (mode == 3) mode = 0;
         at = (mode == 1) ? 8 * $urandom_range(n - 1) + $urandom_range(7, 1)
            : (mode == 2) ? $urandom_range(n - 1) : 0;
         run_transfer(ADDR_W'($urandom), n, $urandom_range(100, 30), $urandom_range(100, 30),
                      1'b0, mode, at, 0, ($urandom_range(1) == 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
